// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
// Execute-stage hazard controller. Tracks the destination tags of the
// instructions sitting in EX and MEM, produces registered operand forward
// selects for the EX muxes, detects load-use hazards (one-cycle stall plus
// bubble), honours a global hold and a branch flush, and keeps a saturating
// stall-cycle counter for performance debug.
//
// Ports:
//   clk, rstn           pipeline clock (rising edge), async active-low reset
//   hold                global freeze; no register changes while high
//   flush               taken branch/jump; the instruction in ID is squashed
//   idValid             ID holds a real instruction
//   idRs, idRt          source register numbers in ID
//   idUsesRs, idUsesRt  ID instruction actually reads Rs / Rt
//   idDest              resolved destination register of the ID instruction
//   idRegWrite          ID instruction writes a register
//   idMemRead           ID instruction is a load
//   forwardA, forwardB  EX operand selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall               load-use hazard (combinational)
//   stallCount          saturating count of stall cycles
module ex_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   hold,
    input  logic                   flush,
    input  logic                   idValid,
    input  logic [4:0]             idRs,
    input  logic [4:0]             idRt,
    input  logic                   idUsesRs,
    input  logic                   idUsesRt,
    input  logic [4:0]             idDest,
    input  logic                   idRegWrite,
    input  logic                   idMemRead,
    output logic [1:0]             forwardA,
    output logic [1:0]             forwardB,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stallCount
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       regWrite;
        logic       memRead;
    } tagEntry_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam tagEntry_t BUBBLE = '{valid: 1'b0, dest: 5'd0, regWrite: 1'b0, memRead: 1'b0};

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    // Forward select for one operand. The EX-stage producer is younger, so
    // it is checked first. A load in EX cannot forward (its data is not ready
    // yet; that case is covered by the stall). Register 0 is never forwarded.
    function automatic logic [1:0] fwdSel(
        input tagEntry_t  exE,
        input tagEntry_t  memE,
        input logic       usesSrc,
        input logic [4:0] src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (usesSrc && exE.valid && exE.regWrite && !exE.memRead &&
            (exE.dest != 5'd0) && (exE.dest == src)) begin
            sel = FWD_EXMEM;
        end else if (usesSrc && memE.valid && memE.regWrite &&
                     (memE.dest != 5'd0) && (memE.dest == src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Only the EX and MEM tags feed any decision; once an instruction leaves
    // MEM its tag has no consumer here, so no WB entry is kept.
    tagEntry_t exE_r;
    tagEntry_t memE_r;

    logic       stall_s;
    logic       bubble_s;
    tagEntry_t  idEntry_s;
    logic [1:0] fwdANext_s;
    logic [1:0] fwdBNext_s;

    // Load-use detection plus the entry/forward values captured on the next advance.
    always_comb begin
        stall_s    = 1'b0;
        bubble_s   = 1'b1;
        idEntry_s  = BUBBLE;
        fwdANext_s = FWD_RF;
        fwdBNext_s = FWD_RF;

        stall_s = idValid && !flush && exE_r.valid && exE_r.memRead &&
                  (exE_r.dest != 5'd0) &&
                  ((idUsesRs && (exE_r.dest == idRs)) ||
                   (idUsesRt && (exE_r.dest == idRt)));

        // flush outranks stall: stall_s already excludes flush.
        bubble_s = stall_s || flush || !idValid;

        if (bubble_s) begin
            idEntry_s  = BUBBLE;
            fwdANext_s = FWD_RF;
            fwdBNext_s = FWD_RF;
        end else begin
            idEntry_s  = '{valid: 1'b1, dest: idDest, regWrite: idRegWrite, memRead: idMemRead};
            fwdANext_s = fwdSel(exE_r, memE_r, idUsesRs, idRs);
            fwdBNext_s = fwdSel(exE_r, memE_r, idUsesRt, idRt);
        end
    end

    assign stall = stall_s;

    // Tag pipeline and registered forward selects; frozen while hold is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exE_r    <= BUBBLE;
            memE_r   <= BUBBLE;
            forwardA <= FWD_RF;
            forwardB <= FWD_RF;
        end else if (hold) begin
            exE_r    <= exE_r;
            memE_r   <= memE_r;
            forwardA <= forwardA;
            forwardB <= forwardB;
        end else begin
            memE_r   <= exE_r;
            exE_r    <= idEntry_s;
            forwardA <= fwdANext_s;
            forwardB <= fwdBNext_s;
        end
    end

    // Saturating stall-cycle counter; counts only edges that actually stall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stallCount <= {STALL_CNT_W{1'b0}};
        end else if (!hold && stall_s && (stallCount != CNT_MAX)) begin
            stallCount <= stallCount + CNT_ONE;
        end else begin
            stallCount <= stallCount;
        end
    end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline hazard controller for the execute stage: tracks destination-register tags of the instructions in EX, MEM and WB, and produces the registered forwardA/forwardB selects for the EX operand muxes. Detects load-use hazards and stalls IF/ID for one cycle while injecting a bubble into EX. Honours a global hold and a branch flush, and counts stall cycles for performance debug. Sits beside the ID/EX pipeline register, fed by decode and driving the EX stage.

## Interface
- STALL_CNT_W, 16, width of the saturating stall-cycle counter
- clk  in  1  pipeline clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- hold  in  1  global freeze (memory wait); no state changes while high
- flush  in  1  taken branch or jump; squashes the instruction currently in ID
- idValid  in  1  ID holds a real instruction
- idRs, idRt  in  5 each  source register numbers in ID
- idUsesRs, idUsesRt  in  1 each  instruction actually reads Rs / Rt
- idDest  in  5  resolved destination register (after RegDst selection)
- idRegWrite, idMemRead  in  1 each  ID instruction writes a register / is a load
- forwardA, forwardB  out  2 each  EX operand selects: 00 register file, 01 EX/MEM result (preData), 10 MEM/WB result (prePreData); 11 never driven
- stall  out  1  load-use hazard; PC and IF/ID hold, ID/EX loads a bubble
- stallCount  out  STALL_CNT_W  saturating count of stall cycles

## Operation
- Internal tag pipeline, each entry {valid, dest[4:0], regWrite, memRead}: exE, memE, wbE.
- Advance, on each rising edge with hold=0: wbE<=memE; memE<=exE; exE<=ID entry, or a bubble (all fields 0) when stall=1, flush=1 or idValid=0.
- stall (combinational from exE and ID inputs): idValid & ~flush & exE.valid & exE.memRead & exE.dest!=0 & ((idUsesRs & exE.dest==idRs) | (idUsesRt & exE.dest==idRt)).
- Forward select for operand A, computed from pre-edge exE/memE and registered on the advancing edge together with the ID entry:
  - 01 if exE.valid & exE.regWrite & ~exE.memRead & exE.dest!=0 & idUsesRs & exE.dest==idRs;
  - else 10 if memE.valid & memE.regWrite & memE.dest!=0 & idUsesRs & memE.dest==idRs;
  - else 00.
- Operand B: same rule using idRt/idUsesRt.
- When a bubble enters EX (stall, flush or idValid=0), forwardA/B register 00.
- Register 0 is never forwarded or stalled on.
- stallCount increments on every edge with hold=0 and stall=1; saturates at all-ones.

## Timing
- Reset (rstn=0, asynchronous): all tag entries cleared, forwardA=forwardB=00, stallCount=0; stall therefore reads 0.
- Forward selects are valid for the whole cycle the instruction occupies EX: one-edge latency from ID.
- Load-use: exactly one stall cycle. The load then sits in MEM and its consumer is re-evaluated in ID; it enters EX while the load is in WB and gets forward select 10.
- hold=1: every register, including stallCount, keeps its value; stall stays combinational and may remain asserted.
- flush and stall together: flush wins. A bubble enters EX, stall deasserts and stallCount does not increment.
- Reset mid-stall: outputs clear immediately. The first edge after release advances normally.
- Both exE and memE match: 01 (younger result) wins.

## Test plan
- add $3,$1,$2 then sub $4,$3,$5 back-to-back -> sub in EX with forwardA=01, forwardB=00, stall never asserted.
- add $3 ; nop ; or $6,$7,$3 -> or in EX with forwardB=10.
- add $3 ; add $3 ; and $8,$3,$3 -> forwardA=forwardB=01 (priority to EX/MEM).
- lw $2,0($1) then add $4,$2,$2 -> stall=1 for exactly one cycle and stallCount 0->1; add reaches EX one cycle late with forwardA=forwardB=10.
- addi $0,$1,5 then add $4,$0,$0 -> forwards 00, no stall. Separately, load-use with flush=1 in the same cycle -> stall=0, bubble in EX, stallCount unchanged.
- Load-use with hold=1 for 3 cycles then released -> stallCount increments only once. Then assert rstn=0 mid-sequence -> forwards 00 and stallCount 0 immediately.
